// File: rtl/engine_result_collector.sv
// Purpose : round-robin collector of NUM_PROC engine result words into the frame-buffer RAM write port.
// Latency : request seen in cycle N -> req_ack in N+1 -> write_iWR_en in N+2; one write per cycle sustained.
// Backpressure: wr_ready low holds S2 stable; S1 fills behind it, then grants stop until S2 drains.
//
// Ports:
//   clk_iCLK, reset           single clock, synchronous active-high reset
//   engine_req/engine_words   per-engine level request and packed {x,y,itr} word
//   req_ack                   registered one-hot acknowledge, one cycle after capture
//   wr_ready                  RAM side accepts a write this cycle
//   write_iWR_en/address_iADDR/writedata_iDATA   RAM write port (x + y*H_RES, itr)
//   pixel_count/frame_done    accepted writes this frame, one-cycle end-of-frame pulse
//   drop_count                saturating count of off-screen results
//   busy                      either pipeline stage holds a word
module engine_result_collector #(
    parameter int NUM_PROC   = 4,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int ITR_WIDTH  = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int WORD_W     = X_WIDTH + Y_WIDTH + ITR_WIDTH
) (
    input  logic                       clk_iCLK,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        engine_req,
    input  logic [NUM_PROC*WORD_W-1:0] engine_words,
    output logic [NUM_PROC-1:0]        req_ack,
    input  logic                       wr_ready,
    output logic                       write_iWR_en,
    output logic [ADDR_WIDTH-1:0]      address_iADDR,
    output logic [ITR_WIDTH-1:0]       writedata_iDATA,
    output logic [ADDR_WIDTH-1:0]      pixel_count,
    output logic                       frame_done,
    output logic [7:0]                 drop_count,
    output logic                       busy
);

    localparam int PTR_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(H_RES * V_RES - 1);

    // Pipeline state
    logic                  s1_vld;
    logic [WORD_W-1:0]     s1_word;
    logic                  s2_vld;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [ITR_WIDTH-1:0]  s2_data;
    logic [NUM_PROC-1:0]   ack_q;
    logic [PTR_W-1:0]      rr_ptr;
    logic [ADDR_WIDTH-1:0] pix_q;
    logic                  frame_q;
    logic [7:0]            drop_q;

    // Handshake terms
    logic s2_xfer;
    logic s1_adv;
    logic s1_free;

    assign s2_xfer = s2_vld && wr_ready;
    assign s1_adv  = s1_vld && (!s2_vld || s2_xfer);
    assign s1_free = !s1_vld || s1_adv;

    // S1 field split and range check
    logic [X_WIDTH-1:0]   s1_x;
    logic [Y_WIDTH-1:0]   s1_y;
    logic [ITR_WIDTH-1:0] s1_itr;
    logic                 on_screen;

    assign s1_x      = s1_word[WORD_W-1 -: X_WIDTH];
    assign s1_y      = s1_word[ITR_WIDTH +: Y_WIDTH];
    assign s1_itr    = s1_word[ITR_WIDTH-1:0];
    assign on_screen = (64'(s1_x) < 64'(H_RES)) && (64'(s1_y) < 64'(V_RES));

    // Round-robin arbitration. The engine acknowledged this cycle still
    // has its request up for the word we already took, so it is masked.
    logic [NUM_PROC-1:0] eligible;
    logic [NUM_PROC-1:0] elig_rot;
    logic [PTR_W-1:0]    gnt_off;
    logic [PTR_W:0]      gnt_sum;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_vld;
    logic [NUM_PROC-1:0] gnt_onehot;
    logic [WORD_W-1:0]   gnt_word;
    logic [PTR_W-1:0]    ptr_next;

    assign eligible = engine_req & ~ack_q;

    always_comb begin
        elig_rot   = '0;
        gnt_off    = '0;
        gnt_sum    = '0;
        gnt_idx    = '0;
        gnt_vld    = 1'b0;
        gnt_onehot = '0;
        gnt_word   = '0;
        ptr_next   = rr_ptr;

        // Rotate so bit 0 is the current highest-priority engine, then
        // take the lowest set bit (loop runs downward so lowest wins).
        elig_rot = NUM_PROC'({eligible, eligible} >> rr_ptr);
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                gnt_off = PTR_W'(k);
            end
        end

        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (gnt_sum >= (PTR_W + 1)'(NUM_PROC)) begin
            gnt_sum = gnt_sum - (PTR_W + 1)'(NUM_PROC);
        end
        gnt_idx = gnt_sum[PTR_W-1:0];

        gnt_vld = s1_free && (|eligible);

        for (int k = 0; k < NUM_PROC; k++) begin
            if (int'(gnt_idx) == k) begin
                gnt_word      = engine_words[k*WORD_W +: WORD_W];
                gnt_onehot[k] = gnt_vld;
            end
        end

        if (gnt_idx == PTR_W'(NUM_PROC - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_iCLK) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_word <= '0;
            s2_vld  <= 1'b0;
            s2_addr <= '0;
            s2_data <= '0;
            ack_q   <= '0;
            rr_ptr  <= '0;
            pix_q   <= '0;
            frame_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            ack_q <= gnt_onehot;

            // S1: a grant refills it even while it advances this cycle
            if (gnt_vld) begin
                s1_vld  <= 1'b1;
                s1_word <= gnt_word;
                rr_ptr  <= ptr_next;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end

            // S2: only loaded with on-screen words; otherwise empties on transfer
            if (s1_adv && on_screen) begin
                s2_vld  <= 1'b1;
                s2_addr <= ADDR_WIDTH'(64'(s1_x) + 64'(s1_y) * 64'(H_RES));
                s2_data <= s1_itr;
            end else if (s2_xfer) begin
                s2_vld <= 1'b0;
            end

            if (s1_adv && !on_screen && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            frame_q <= 1'b0;
            if (s2_xfer) begin
                if (pix_q == LAST_PIX) begin
                    pix_q   <= '0;
                    frame_q <= 1'b1;
                end else begin
                    pix_q <= pix_q + 1'b1;
                end
            end
        end
    end

    assign req_ack         = ack_q;
    assign write_iWR_en    = s2_vld;
    assign address_iADDR   = s2_addr;
    assign writedata_iDATA = s2_data;
    assign pixel_count     = pix_q;
    assign frame_done      = frame_q;
    assign drop_count      = drop_q;
    assign busy            = s1_vld || s2_vld;

endmodule

// File: doc/engine_result_collector.md
Name: engine_result_collector

Overview:
- Parametrised successor to the fixed 4-engine result path. Replaces the hard-wired one-hot arbiter and the shared tri-state result bus.
- Takes result words from NUM_PROC Mandelbrot engines on a packed parallel bus and arbitrates between them round-robin.
- Converts {x,y} to a linear frame-buffer address and drives the dual-port RAM write port of the VGA block.
- Tracks pixels written per frame, drops off-screen results, and honours a write-ready stall from the RAM side.

Parameters:
- NUM_PROC, 4, number of engines (1..16).
- X_WIDTH, 10, x coordinate width.
- Y_WIDTH, 9, y coordinate width.
- ITR_WIDTH, 8, iteration/colour data width.
- H_RES, 640, pixels per line; also the address multiplier.
- V_RES, 480, lines per frame.
- ADDR_WIDTH, 19, RAM address width; must satisfy 2**ADDR_WIDTH >= H_RES*V_RES.
- WORD_W, X_WIDTH+Y_WIDTH+ITR_WIDTH, derived result word width.

Ports:
- clk_iCLK  in  1  engine clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- engine_req  in  NUM_PROC  level request; bit i high while engine i holds a valid result.
- engine_words  in  NUM_PROC*WORD_W  engine i word at [i*WORD_W +: WORD_W], packed {x,y,itr} with x in the MSBs. Stable while its request is high.
- req_ack  out  NUM_PROC  registered one-hot, one-cycle acknowledge. The word was captured on the previous edge.
- wr_ready  in  1  RAM side can accept a write this cycle.
- write_iWR_en  out  1  write valid.
- address_iADDR  out  ADDR_WIDTH  x + y*H_RES.
- writedata_iDATA  out  ITR_WIDTH  iteration value.
- pixel_count  out  ADDR_WIDTH  accepted writes in the current frame.
- frame_done  out  1  one-cycle pulse when a frame completes.
- drop_count  out  8  saturating count of off-screen results.
- busy  out  1  S1 or S2 valid.

Behaviour:
- **Reset.** All outputs are 0, S1 and S2 are invalid, and the round-robin pointer is set so engine 0 has highest priority. Reset mid-operation discards in-flight words without acknowledging them; engines keep requesting and are re-served.

- **Arbitration.**
  - Eligible set = engine_req AND NOT req_ack. This masks the engine acknowledged this cycle, whose request is still high.
  - A grant is issued only if S1 will be free at the edge: S1 empty, or S1 advancing.
  - Priority is round-robin, starting at (last granted + 1) mod NUM_PROC.
  - On grant to engine g: its word is latched into S1, req_ack[g] goes high the next cycle for exactly one cycle, and the pointer moves to g+1.
  - At most one grant per cycle.

- **S1 → S2.**
  - S1 advances when S2 is empty or S2 is accepted this cycle (write_iWR_en and wr_ready).
  - Range check on advance: if x >= H_RES or y >= V_RES, the word is discarded, S2 is not loaded, and drop_count increments (holds at 255).
  - Otherwise S2 loads address = x + y*H_RES, computed at full precision then truncated to ADDR_WIDTH, and data = itr.

- **Output.**
  - write_iWR_en = S2 valid.
  - While wr_ready is low, write_iWR_en, address_iADDR and writedata_iDATA hold stable.
  - A transfer occurs only when write_iWR_en and wr_ready are both high.

- **Latency and throughput.**
  - With idle pipeline and wr_ready high, a request seen in cycle N produces req_ack in N+1 and write_iWR_en in N+2.
  - Sustained throughput is one write per cycle.
  - With wr_ready held low, the pipeline fills (S1 and S2), after which no further grants are issued.

- **Frame accounting.**
  - pixel_count increments on each transfer.
  - A transfer that occurs while pixel_count = H_RES*V_RES-1 wraps the count to 0 and pulses frame_done in the next cycle.
  - Dropped words do not count toward pixel_count.

- **Simultaneous events.** A drop and a transfer in the same cycle update both counters independently. A grant and an S1 advance in the same cycle are legal.

Test Plan:
- Single request: after reset, engine 2 requests {x=5,y=3,itr=0x7F} -> req_ack=4'b0100 in cycle N+1, write_iWR_en in N+2 with address=1925, data=0x7F.
- Fairness: all 4 engines request continuously -> grant order 0,1,2,3,0,1,...; no engine acknowledged twice within 4 grants; one write per cycle.
- Stall: wr_ready low for 10 cycles during a stream -> write outputs held constant; at most 2 acks issued; no loss or duplication after wr_ready rises.
- Off-screen: word x=640,y=0 -> acked, no write, drop_count=1; 300 such words -> drop_count=255.
- Frame wrap: H_RES=4, V_RES=2, eight on-screen writes -> pixel_count 0..7 then 0, with frame_done pulsing once, one cycle after the 8th transfer.
- Reset mid-stream: reset asserted while S1 and S2 are full -> the next cycle shows write_iWR_en=0, req_ack=0, counters=0; held requests are re-served starting from engine 0.
